// File: rtl/riscv_ctrl_pkg.sv
// Types and constants shared by the fetch controller and the decode/execute stages.
package riscv_ctrl_pkg;

    localparam int REG_ADDR_W   = 5;
    localparam int DEFAULT_XLEN = 32;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_STALL  = 2'd1,
        IMEM_WAIT = 2'd2,
        REDIRECT  = 2'd3
    } fsm_state_e;

    typedef struct packed {
        logic pc_stall;
        logic pc_load;
        logic imem_kill;
        logic if_id_stall;
        logic if_id_flush;
        logic id_ex_flush;
    } ctrl_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the EX load and the ID sources.
module load_use_detect
    import riscv_ctrl_pkg::*;
(
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    output logic                  lu
);

    // x0 is hardwired to zero, so a load targeting it never creates a hazard.
    assign lu = ex_mem_read && (ex_rd != '0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                 (id_use_rs2 && (id_rs2 == ex_rd)));

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// PC sequencing and IF/ID, ID/EX stall/flush control with saturating perf counters.
module fetch_hazard_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int XLEN        = DEFAULT_XLEN,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  imem_ready,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_branch_taken,
    input  logic [XLEN-1:0]       ex_pc,
    input  logic [XLEN-1:0]       ex_offset,
    output logic                  pc_stall,
    output logic                  pc_load,
    output logic [XLEN-1:0]       pc_target,
    output logic                  imem_kill,
    output logic                  if_id_stall,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic [1:0]            state_o,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      redirect_cnt
);

    localparam int              FC_W    = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
    localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_DEPTH - 1);

    fsm_state_e       state_q, state_d;
    logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [XLEN-1:0]  target_q, target_d;
    ctrl_t            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;
    logic             lu;
    logic             enter_redirect;

    load_use_detect u_load_use_detect (
        .ex_mem_read (ex_mem_read),
        .ex_rd       (ex_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .lu          (lu)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
        target_d       = target_q;
        enter_redirect = 1'b0;
        case (state_q)
            RUN: begin
                if (ex_branch_taken)  enter_redirect = 1'b1;
                else if (lu)          state_d = LU_STALL;
                else if (!imem_ready) state_d = IMEM_WAIT;
            end
            LU_STALL: begin
                if (ex_branch_taken)  enter_redirect = 1'b1;
                else if (!imem_ready) state_d = IMEM_WAIT;
                else                  state_d = RUN;
            end
            IMEM_WAIT: begin
                if (ex_branch_taken)  enter_redirect = 1'b1;
                else if (imem_ready)  state_d = RUN;
            end
            REDIRECT: begin
                // Branches and hazards seen here belong to squashed wrong-path slots.
                if (flush_cnt_q == '0) state_d = RUN;
                else                   flush_cnt_d = flush_cnt_q - 1'b1;
            end
            default: state_d = RUN;
        endcase
        if (enter_redirect) begin
            state_d     = REDIRECT;
            flush_cnt_d = FC_LOAD;
            target_d    = ex_pc + ex_offset;
        end
    end

    // Outputs are decoded from the next state and registered, so they are pure Moore.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            LU_STALL: begin
                ctrl_d.pc_stall    = 1'b1;
                ctrl_d.if_id_stall = 1'b1;
                ctrl_d.id_ex_flush = 1'b1;
            end
            IMEM_WAIT: begin
                ctrl_d.pc_stall    = 1'b1;
                ctrl_d.if_id_flush = 1'b1;
            end
            REDIRECT: begin
                ctrl_d.pc_load     = enter_redirect;
                ctrl_d.imem_kill   = enter_redirect;
                ctrl_d.if_id_flush = 1'b1;
                ctrl_d.id_ex_flush = 1'b1;
            end
            default: ;
        endcase
        stall_cnt_d    = (ctrl_d.pc_stall && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        redirect_cnt_d = (enter_redirect && (redirect_cnt_q != '1)) ? redirect_cnt_q + 1'b1
                                                                    : redirect_cnt_q;
    end

    // NOTE: sequential state uses non-blocking assignments only, so flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            flush_cnt_q    <= '0;
            target_q       <= '0;
            ctrl_q         <= '0;
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            target_q       <= target_d;
            ctrl_q         <= ctrl_d;
            stall_cnt_q    <= stall_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign pc_stall     = ctrl_q.pc_stall;
    assign pc_load      = ctrl_q.pc_load;
    assign imem_kill    = ctrl_q.imem_kill;
    assign if_id_stall  = ctrl_q.if_id_stall;
    assign if_id_flush  = ctrl_q.if_id_flush;
    assign id_ex_flush  = ctrl_q.id_ex_flush;
    assign pc_target    = target_q;
    assign state_o      = state_q;
    assign stall_cnt    = stall_cnt_q;
    assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Scoreboard bench: directed per-cycle vectors push expectations, a monitor pops and compares.
module tb_fetch_hazard_ctrl;

    typedef struct packed {
        logic        rdy;
        logic        mr;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        u1;
        logic        u2;
        logic        br;
        logic [31:0] pc;
        logic [31:0] off;
    } in_t;

    typedef struct {
        int          id;
        logic [1:0]  st;
        logic [5:0]  ctrl;
        logic [31:0] tgt;
        logic [15:0] sc;
        logic [15:0] rc;
    } exp_t;

    localparam logic [5:0] C_RUN = 6'b000000;
    localparam logic [5:0] C_LU  = 6'b100101;
    localparam logic [5:0] C_IW  = 6'b100010;
    localparam logic [5:0] C_RD1 = 6'b011011;
    localparam logic [5:0] C_RDN = 6'b000011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_ready, id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic [31:0] ex_pc, ex_offset;

    logic        pc_stall, pc_load, imem_kill, if_id_stall, if_id_flush, id_ex_flush;
    logic [31:0] pc_target;
    logic [1:0]  state_o;
    logic [15:0] stall_cnt, redirect_cnt;

    logic        n_pc_stall, n_pc_load, n_imem_kill, n_if_id_stall, n_if_id_flush, n_id_ex_flush;
    logic [31:0] n_pc_target;
    logic [1:0]  n_state_o;
    logic [1:0]  n_stall_cnt, n_redirect_cnt;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   step_id  = 0;

    always #5 clk = ~clk;

    fetch_hazard_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .imem_ready(imem_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .ex_pc(ex_pc), .ex_offset(ex_offset),
        .pc_stall(pc_stall), .pc_load(pc_load), .pc_target(pc_target), .imem_kill(imem_kill),
        .if_id_stall(if_id_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .state_o(state_o), .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt)
    );

    fetch_hazard_ctrl #(.CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .imem_ready(imem_ready),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
        .ex_pc(ex_pc), .ex_offset(ex_offset),
        .pc_stall(n_pc_stall), .pc_load(n_pc_load), .pc_target(n_pc_target),
        .imem_kill(n_imem_kill), .if_id_stall(n_if_id_stall), .if_id_flush(n_if_id_flush),
        .id_ex_flush(n_id_ex_flush), .state_o(n_state_o), .stall_cnt(n_stall_cnt),
        .redirect_cnt(n_redirect_cnt)
    );

    wire [5:0] act_ctrl = {pc_stall, pc_load, imem_kill, if_id_stall, if_id_flush, id_ex_flush};

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [1:0] sat2(input logic [15:0] v);
        return (v > 16'd3) ? 2'd3 : v[1:0];
    endfunction

    function automatic in_t f_idle();
        in_t i;
        i = '0;
        i.rdy = 1'b1;
        return i;
    endfunction

    function automatic in_t f_lu(input logic [4:0] rd, rs1, rs2, input logic u1, u2);
        in_t i;
        i = f_idle();
        i.mr = 1'b1; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.u1 = u1; i.u2 = u2;
        return i;
    endfunction

    function automatic in_t f_br(input logic [31:0] pc, off);
        in_t i;
        i = f_idle();
        i.br = 1'b1; i.pc = pc; i.off = off;
        return i;
    endfunction

    function automatic in_t f_wait();
        in_t i;
        i = f_idle();
        i.rdy = 1'b0;
        return i;
    endfunction

    task automatic apply(input in_t i);
        imem_ready = i.rdy; ex_mem_read = i.mr; ex_rd = i.rd; id_rs1 = i.rs1; id_rs2 = i.rs2;
        id_use_rs1 = i.u1; id_use_rs2 = i.u2; ex_branch_taken = i.br;
        ex_pc = i.pc; ex_offset = i.off;
    endtask

    // One cycle: drive at negedge, expect the registered response after the next posedge.
    task automatic cyc(input in_t i, input logic [1:0] st, input logic [5:0] c,
                       input logic [31:0] t, input logic [15:0] s, input logic [15:0] r);
        exp_t e;
        @(negedge clk);
        apply(i);
        step_id++;
        e.id = step_id; e.st = st; e.ctrl = c; e.tgt = t; e.sc = s; e.rc = r;
        sb.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " state"}, 64'(state_o), 64'd0);
        check({tag, " ctrl"}, 64'(act_ctrl), 64'd0);
        check({tag, " target"}, 64'(pc_target), 64'd0);
        check({tag, " stall_cnt"}, 64'(stall_cnt), 64'd0);
        check({tag, " redirect_cnt"}, 64'(redirect_cnt), 64'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("step%0d state", e.id), 64'(state_o), 64'(e.st));
                check($sformatf("step%0d ctrl", e.id), 64'(act_ctrl), 64'(e.ctrl));
                check($sformatf("step%0d target", e.id), 64'(pc_target), 64'(e.tgt));
                check($sformatf("step%0d stall_cnt", e.id), 64'(stall_cnt), 64'(e.sc));
                check($sformatf("step%0d redirect_cnt", e.id), 64'(redirect_cnt), 64'(e.rc));
                check($sformatf("step%0d sat stall_cnt", e.id), 64'(n_stall_cnt),
                      64'(sat2(e.sc)));
                check($sformatf("step%0d sat redirect_cnt", e.id), 64'(n_redirect_cnt),
                      64'(sat2(e.rc)));
            end
        end
    end

    initial begin : stimulus
        in_t i;
        apply(f_idle());
        // Reset held with random inputs: every output stays zero.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            imem_ready = 1'($urandom); ex_mem_read = 1'($urandom); ex_rd = 5'($urandom);
            id_rs1 = 5'($urandom); id_rs2 = 5'($urandom); id_use_rs1 = 1'($urandom);
            id_use_rs2 = 1'($urandom); ex_branch_taken = 1'($urandom);
            ex_pc = $urandom; ex_offset = $urandom;
            @(posedge clk);
            #1 check_all_zero($sformatf("reset%0d", k));
        end
        @(negedge clk);
        apply(f_idle());
        rst_n = 1'b1;

        cyc(f_idle(),                       2'd0, C_RUN, 32'h0,    16'd0, 16'd0);
        cyc(f_lu(5'd5, 5'd0, 5'd5, 0, 1),   2'd1, C_LU,  32'h0,    16'd1, 16'd0);
        cyc(f_idle(),                       2'd0, C_RUN, 32'h0,    16'd1, 16'd0);
        cyc(f_lu(5'd0, 5'd0, 5'd0, 0, 1),   2'd0, C_RUN, 32'h0,    16'd1, 16'd0);
        cyc(f_lu(5'd7, 5'd7, 5'd3, 1, 0),   2'd1, C_LU,  32'h0,    16'd2, 16'd0);
        cyc(f_idle(),                       2'd0, C_RUN, 32'h0,    16'd2, 16'd0);
        cyc(f_br(32'h100, 32'hFFFF_FFF0),   2'd3, C_RD1, 32'hF0,   16'd2, 16'd1);
        i = f_br(32'h200, 32'h40);
        i.mr = 1'b1; i.rd = 5'd9; i.rs1 = 5'd9; i.u1 = 1'b1;
        cyc(i,                              2'd3, C_RDN, 32'hF0,   16'd2, 16'd1);
        cyc(f_idle(),                       2'd0, C_RUN, 32'hF0,   16'd2, 16'd1);
        cyc(f_idle(),                       2'd0, C_RUN, 32'hF0,   16'd2, 16'd1);
        cyc(f_br(32'hFFFF_FFFC, 32'h8),     2'd3, C_RD1, 32'h4,    16'd2, 16'd2);
        cyc(f_idle(),                       2'd3, C_RDN, 32'h4,    16'd2, 16'd2);
        cyc(f_idle(),                       2'd0, C_RUN, 32'h4,    16'd2, 16'd2);
        i = f_br(32'h40, 32'h20);
        i.rdy = 1'b0; i.mr = 1'b1; i.rd = 5'd4; i.rs2 = 5'd4; i.u2 = 1'b1;
        cyc(i,                              2'd3, C_RD1, 32'h60,   16'd2, 16'd3);
        cyc(f_idle(),                       2'd3, C_RDN, 32'h60,   16'd2, 16'd3);
        cyc(f_idle(),                       2'd0, C_RUN, 32'h60,   16'd2, 16'd3);
        cyc(f_wait(),                       2'd2, C_IW,  32'h60,   16'd3, 16'd3);
        cyc(f_wait(),                       2'd2, C_IW,  32'h60,   16'd4, 16'd3);
        cyc(f_wait(),                       2'd2, C_IW,  32'h60,   16'd5, 16'd3);
        cyc(f_idle(),                       2'd0, C_RUN, 32'h60,   16'd5, 16'd3);
        cyc(f_wait(),                       2'd2, C_IW,  32'h60,   16'd6, 16'd3);
        i = f_br(32'h1000, 32'h10);
        i.rdy = 1'b0;
        cyc(i,                              2'd3, C_RD1, 32'h1010, 16'd6, 16'd4);
        cyc(f_idle(),                       2'd3, C_RDN, 32'h1010, 16'd6, 16'd4);
        cyc(f_idle(),                       2'd0, C_RUN, 32'h1010, 16'd6, 16'd4);
        i = f_lu(5'd12, 5'd12, 5'd0, 1, 0);
        i.rdy = 1'b0;
        cyc(i,                              2'd1, C_LU,  32'h1010, 16'd7, 16'd4);
        cyc(f_wait(),                       2'd2, C_IW,  32'h1010, 16'd8, 16'd4);
        cyc(f_idle(),                       2'd0, C_RUN, 32'h1010, 16'd8, 16'd4);
        cyc(f_br(32'h80, 32'h4),            2'd3, C_RD1, 32'h84,   16'd8, 16'd5);
        cyc(f_idle(),                       2'd3, C_RDN, 32'h84,   16'd8, 16'd5);

        // Reset asserted in the second REDIRECT cycle takes effect without a clock edge.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1 check_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;

        cyc(f_lu(5'd5, 5'd0, 5'd5, 0, 1),   2'd1, C_LU,  32'h0,    16'd1, 16'd0);
        cyc(f_idle(),                       2'd0, C_RUN, 32'h0,    16'd1, 16'd0);

        repeat (4) @(posedge clk);
        #3;
        check("scoreboard drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
